// File: rtl/node_seq_pkg.sv
// node_seq_pkg: shared widths, sentinel node ID and sequencer states.
// OBSTACLE_HOLD_EN adds the HOLD state.
package node_seq_pkg;

  localparam int NODE_W = 5;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LEN_W  = IDX_W + 1;

  localparam logic [NODE_W-1:0] INVALID_NODE = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DROP,
    S_DONE
`ifdef OBSTACLE_HOLD_EN
    ,
    S_HOLD
`endif
  } state_t;

endpackage

// File: rtl/node_sequencer_path_buffer.sv
// path_buffer: DEPTH x NODE_W register file.
// One write port, two async read ports (node and next node).
module path_buffer
  import node_seq_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  wa,
  input  logic [NODE_W-1:0] wd,
  input  logic [IDX_W-1:0]  ra0,
  input  logic [IDX_W-1:0]  ra1,
  output logic [NODE_W-1:0] rd0,
  output logic [NODE_W-1:0] rd1
);

  logic [NODE_W-1:0] mem [DEPTH];

  // path storage, written one slot per accepted load
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

endmodule

// File: rtl/node_sequencer.sv
// node_sequencer: walks a stored node path, fires a timed delatch pulse.
// OBSTACLE_HOLD_EN enables obstacle-qualified HOLD and fault_count.
module node_sequencer
  import node_seq_pkg::*;
#(
  parameter int DELATCH_CYCLES = 25000,
  parameter int OBS_FILTER     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [NODE_W-1:0] wr_data,
  input  logic              start,
  input  logic              abort,
  input  logic [NODE_W-1:0] drop_node,
  input  logic              node_tick,
  input  logic              obstacle,
  output logic [NODE_W-1:0] current_node,
  output logic [NODE_W-1:0] future_node,
  output logic              en,
  output logic              delatch,
  output logic              done,
  output logic              load_err,
  output logic              missed_tick,
  output logic [3:0]        fault_count
);

  localparam int CW =
    (DELATCH_CYCLES > 1) ? $clog2(DELATCH_CYCLES) : 1;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  len, len_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt, idx_p1;
  logic [NODE_W-1:0] drop_q, drop_nxt;
  logic              matched, matched_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              load_err_nxt, missed_nxt;
  logic              buf_we;
  logic [IDX_W-1:0]  buf_wa;
  logic [NODE_W-1:0] rd_cur, rd_nxt;
  logic              is_last;

`ifdef OBSTACLE_HOLD_EN
  localparam int OW = $clog2(OBS_FILTER) + 1;
  logic [OW-1:0] obs_cnt, obs_nxt;
  logic [3:0]    fault, fault_nxt;
  assign fault_count = fault;
`else
  logic unused;
  assign unused      = obstacle ^ (OBS_FILTER == 0);
  assign fault_count = 4'd0;
`endif

  assign idx_p1  = idx + IDX_W'(1);
  assign is_last = ({1'b0, idx} == len - LEN_W'(1));

  path_buffer u_buf (
    .clk (clk),
    .we  (buf_we),
    .wa  (buf_wa),
    .wd  (wr_data),
    .ra0 (idx),
    .ra1 (idx_p1),
    .rd0 (rd_cur),
    .rd1 (rd_nxt)
  );

  // state, counters and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      len         <= '0;
      idx         <= '0;
      drop_q      <= '0;
      matched     <= 1'b0;
      cnt         <= '0;
      load_err    <= 1'b0;
      missed_tick <= 1'b0;
`ifdef OBSTACLE_HOLD_EN
      obs_cnt     <= '0;
      fault       <= '0;
`endif
    end else begin
      state       <= state_nxt;
      len         <= len_nxt;
      idx         <= idx_nxt;
      drop_q      <= drop_nxt;
      matched     <= matched_nxt;
      cnt         <= cnt_nxt;
      load_err    <= load_err_nxt;
      missed_tick <= missed_nxt;
`ifdef OBSTACLE_HOLD_EN
      obs_cnt     <= obs_nxt;
      fault       <= fault_nxt;
`endif
    end
  end

  // next-state: loading, traversal, drop pulse timing
  always_comb begin
    state_nxt    = state;
    len_nxt      = len;
    idx_nxt      = idx;
    drop_nxt     = drop_q;
    matched_nxt  = matched;
    cnt_nxt      = cnt;
    load_err_nxt = load_err;
    missed_nxt   = missed_tick;
    buf_we       = 1'b0;
    buf_wa       = len[IDX_W-1:0];
`ifdef OBSTACLE_HOLD_EN
    obs_nxt      = '0;
    fault_nxt    = fault;
`endif
    if (abort) begin
      state_nxt   = S_IDLE;
      len_nxt     = '0;
      idx_nxt     = '0;
      matched_nxt = 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (len >= LEN_W'(2)) begin
              state_nxt   = S_RUN;
              idx_nxt     = '0;
              drop_nxt    = drop_node;
              matched_nxt = 1'b0;
            end
          end else if (wr_en) begin
            if (state == S_DONE) begin
              buf_we    = 1'b1;
              buf_wa    = '0;
              len_nxt   = LEN_W'(1);
              state_nxt = S_IDLE;
            end else if (len == LEN_W'(DEPTH)) begin
              load_err_nxt = 1'b1;
            end else begin
              buf_we  = 1'b1;
              len_nxt = len + LEN_W'(1);
            end
          end
        end
        S_RUN: begin
`ifdef OBSTACLE_HOLD_EN
          if (obstacle) obs_nxt = obs_cnt + OW'(1);
          if (obstacle && obs_cnt == OW'(OBS_FILTER - 1)) begin
            state_nxt = S_HOLD;
            obs_nxt   = '0;
            if (fault != 4'hf) fault_nxt = fault + 4'd1;
            if (node_tick) missed_nxt = 1'b1;
          end else
`endif
          if (node_tick) begin
            idx_nxt = idx_p1;
            if (!matched && rd_nxt == drop_q) begin
              state_nxt   = S_DROP;
              matched_nxt = 1'b1;
              cnt_nxt     = CW'(DELATCH_CYCLES - 1);
            end else if ({1'b0, idx_p1} == len - LEN_W'(1)) begin
              state_nxt = S_DONE;
            end
          end
        end
        S_DROP: begin
          if (node_tick) missed_nxt = 1'b1;
          if (cnt == '0) state_nxt = is_last ? S_DONE : S_RUN;
          else           cnt_nxt   = cnt - CW'(1);
        end
`ifdef OBSTACLE_HOLD_EN
        S_HOLD: begin
          if (node_tick) missed_nxt = 1'b1;
          if (!obstacle) begin
            if (obs_cnt == OW'(OBS_FILTER - 1)) state_nxt = S_RUN;
            else obs_nxt = obs_cnt + OW'(1);
          end
        end
`endif
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // node outputs decoded from registered state and index
  always_comb begin
    current_node = INVALID_NODE;
    future_node  = INVALID_NODE;
    if (state != S_IDLE) begin
      current_node = rd_cur;
      if (state != S_DONE && !is_last) future_node = rd_nxt;
    end
  end

  assign en      = (state == S_RUN) || (state == S_DROP);
  assign delatch = (state == S_DROP);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_node_sequencer.sv
// tb_node_sequencer: directed + random stimulus, queue scoreboard
// against a path-level reference model.
module tb_node_sequencer;

  localparam int DL  = 4;
  localparam int INV = 31;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DROP = 2;
  localparam int M_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_data = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] drop_node = '0;
  logic       node_tick = 1'b0;
  logic       obstacle = 1'b0;
  logic [4:0] current_node, future_node;
  logic       en, delatch, done, load_err, missed_tick;
  logic [3:0] fault_count;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int cur; int fut;
    bit en; bit dl; bit dn; bit le; bit mt;
  } exp_t;
  exp_t sbq[$];

  int path[$];
  int mode = M_IDLE;
  int pos, tgt, left;
  bit fired, lerr, miss;

  node_sequencer #(
    .DELATCH_CYCLES (DL),
    .OBS_FILTER     (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .start        (start),
    .abort        (abort),
    .drop_node    (drop_node),
    .node_tick    (node_tick),
    .obstacle     (obstacle),
    .current_node (current_node),
    .future_node  (future_node),
    .en           (en),
    .delatch      (delatch),
    .done         (done),
    .load_err     (load_err),
    .missed_tick  (missed_tick),
    .fault_count  (fault_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act,
                       input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic model(input bit r, input bit w, input int d,
                       input bit s, input bit a, input int dn,
                       input bit t);
    if (!r) begin
      path.delete(); mode = M_IDLE; pos = 0;
      lerr = 0; miss = 0; fired = 0;
    end else if (a) begin
      path.delete(); mode = M_IDLE; pos = 0;
    end else begin
      case (mode)
        M_IDLE, M_DONE: begin
          if (s) begin
            if (path.size() >= 2) begin
              mode = M_RUN; pos = 0; tgt = dn; fired = 0;
            end
          end else if (w) begin
            if (mode == M_DONE) begin
              path.delete(); path.push_back(d); mode = M_IDLE;
            end else if (path.size() == 16) lerr = 1;
            else path.push_back(d);
          end
        end
        M_RUN: if (t) begin
          pos++;
          if (!fired && path[pos] == tgt) begin
            mode = M_DROP; fired = 1; left = DL;
          end else if (pos == path.size() - 1) mode = M_DONE;
        end
        M_DROP: begin
          if (t) miss = 1;
          left--;
          if (left == 0)
            mode = (pos == path.size() - 1) ? M_DONE : M_RUN;
        end
        default: mode = M_IDLE;
      endcase
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.cur = INV;
    e.fut = INV;
    if (mode != M_IDLE) begin
      e.cur = path[pos];
      if (mode != M_DONE && pos != path.size() - 1)
        e.fut = path[pos + 1];
    end
    e.en = (mode == M_RUN) || (mode == M_DROP);
    e.dl = (mode == M_DROP);
    e.dn = (mode == M_DONE);
    e.le = lerr;
    e.mt = miss;
    return e;
  endfunction

  task automatic step(input bit r, input bit w, input int d,
                      input bit s, input bit a, input int dn,
                      input bit t, input bit o = 1'b0);
    @(negedge clk);
    rst_n = r; wr_en = w; wr_data = 5'(d); start = s;
    abort = a; drop_node = 5'(dn); node_tick = t; obstacle = o;
    model(r, w, d, s, a, dn, t);
    sbq.push_back(snap());
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic wr(input int d);  step(1, 1, d, 0, 0, 0, 0); endtask
  task automatic go(input int dn); step(1, 0, 0, 1, 0, dn, 0); endtask
  task automatic tick();           step(1, 0, 0, 0, 0, 0, 1); endtask
  task automatic abrt();           step(1, 0, 0, 0, 1, 0, 0); endtask
  task automatic settle();
    @(posedge clk); #2;
  endtask

  // scoreboard monitor
  initial begin : mon
    exp_t e;
    bit ok;
    forever begin
      @(posedge clk); #1;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        ok = (int'(current_node) == e.cur) &&
             (int'(future_node) == e.fut) &&
             (en == e.en) && (delatch == e.dl) &&
             (done == e.dn) && (load_err == e.le) &&
             (missed_tick == e.mt) && (fault_count == 4'd0);
        n_chk++;
        if (ok) n_pass++;
        else $display(
          "FAIL sb t=%0t cur %0d/%0d fut %0d/%0d en %0b/%0b dl %0b/%0b dn %0b/%0b le %0b/%0b mt %0b/%0b fc %0d/0 (got/exp)",
          $time, current_node, e.cur, future_node, e.fut,
          en, e.en, delatch, e.dl, done, e.dn,
          load_err, e.le, missed_tick, e.mt, fault_count);
      end
    end
  end

  initial begin : stim
    int hi;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    settle();
    check("rst_cur", current_node, INV);
    check("rst_fut", future_node, INV);
    check("rst_en", en, 0);

    wr(22); wr(10); wr(11); wr(23);
    go(10);
    settle();
    check("run_cur", current_node, 22);
    check("run_fut0", future_node, 10);
    check("run_en", en, 1);
    tick();
    settle();
    check("fut1", future_node, 11);
    check("dl_on", delatch, 1);
    hi = 1;
    repeat (6) begin
      idle(1); settle();
      if (delatch) hi++;
    end
    check("dl_width", hi, DL);
    tick(); settle();
    check("fut2", future_node, 23);
    tick(); settle();
    check("fut3", future_node, INV);
    check("done3", done, 1);
    check("cur3", current_node, 23);
    idle(2);

    abrt();
    wr(5); go(3); settle();
    check("short_en", en, 0);
    for (int i = 0; i < 16; i++) wr(i);
    settle();
    check("load_err", load_err, 1);
    idle(1);

    abrt();
    wr(1); wr(2); wr(3); go(2);
    tick(); idle(1); tick(); settle();
    check("missed", missed_tick, 1);
    check("drop_idx", current_node, 2);
    check("drop_dl", delatch, 1);
    idle(6); tick(); idle(2);

    abrt();
    wr(4); wr(5); wr(6); go(5);
    tick(); settle();
    check("ab_dl_pre", delatch, 1);
    abrt(); settle();
    check("ab_dl", delatch, 0);
    check("ab_cur", current_node, INV);
    check("ab_fut", future_node, INV);
    check("ab_en", en, 0);

    wr(7); wr(8); wr(9); go(0); tick();
    step(0, 0, 0, 0, 0, 0, 0);
    settle();
    check("mr_en", en, 0);
    check("mr_cur", current_node, INV);
    check("mr_le", load_err, 0);
    check("mr_mt", missed_tick, 0);

    wr(1); wr(2);
    step(1, 1, 9, 1, 0, 7, 0);
    tick(); settle();
    check("ws_done", done, 1);
    wr(12); settle();
    check("rs_done", done, 0);
    check("rs_cur", current_node, INV);
    wr(13); go(0); settle();
    check("rs_cur2", current_node, 12);
    check("rs_fut2", future_node, 13);
    abrt();

    for (int i = 0; i < 3000; i++)
      step(($urandom % 500) != 0, ($urandom % 4) == 0,
           int'($urandom % 8), ($urandom % 16) == 0,
           ($urandom % 64) == 0, int'($urandom % 8),
           ($urandom % 5) == 0, 1'($urandom % 2));

    idle(2);
    repeat (4) @(posedge clk);
    #2;
    check("drain", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
